// File: rtl/jump_pkg.sv
// Shared opcodes, function codes and sequencer states for the jump/link datapath.
package jump_pkg;

  // Primary opcodes (instru[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (instru[5:0])
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LINK_WAIT = 2'd1,
    REDIRECT  = 2'd2
  } state_e;

  // Word-aligned register target: low two bits forced to zero
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/jump_link_ctrl_if.sv
// Decode, register-file write port and fetch-redirect signals of the jump/link sequencer.
interface jump_link_ctrl_if;

  logic [31:0] instru;
  logic        instr_valid;
  logic [31:0] pc_in;
  logic [31:0] rs_data;
  logic        alu_wr_req;
  logic [4:0]  alu_wr_addr;
  logic [31:0] alu_wr_data;
  logic        alu_wr_gnt;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pc_out;
  logic        pc_load;
  logic        stall;
  logic        addr_err;

  // Upstream side: decode stage, ALU writeback and RF/fetch consumers
  modport master (
    output instru, instr_valid, pc_in, rs_data,
    output alu_wr_req, alu_wr_addr, alu_wr_data,
    input  alu_wr_gnt, rf_we, rf_waddr, rf_wdata,
    input  pc_out, pc_load, stall, addr_err
  );

  // Sequencer side
  modport slave (
    input  instru, instr_valid, pc_in, rs_data,
    input  alu_wr_req, alu_wr_addr, alu_wr_data,
    output alu_wr_gnt, rf_we, rf_waddr, rf_wdata,
    output pc_out, pc_load, stall, addr_err
  );

endinterface

// File: rtl/jump_target_calc.sv
// Combinational jump decoder: classifies J/JAL/JR/JALR and computes target and link value.
module jump_target_calc
  import jump_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic [31:0] instru,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs_data,
  output logic [31:0] target,
  output logic [31:0] link_val,
  output logic [4:0]  link_rd,
  output logic        is_jump,
  output logic        is_link,
  output logic        misaligned
);

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rd_s;
  logic [31:0] pc4_s;

  assign opcode_s = instru[31:26];
  assign funct_s  = instru[5:0];
  assign rd_s     = instru[15:11];
  assign pc4_s    = pc_in + 32'd4;   // wraps mod 2^32, no delay slot
  assign link_val = pc4_s;

  // Decode the jump class and select the absolute or register target
  always_comb begin
    target     = 32'h0000_0000;
    link_rd    = 5'd0;
    is_jump    = 1'b0;
    is_link    = 1'b0;
    misaligned = 1'b0;
    case (opcode_s)
      OP_J: begin
        is_jump = 1'b1;
        target  = {pc4_s[31:28], instru[25:0], 2'b00};
      end
      OP_JAL: begin
        is_jump = 1'b1;
        is_link = 1'b1;
        link_rd = LINK_REG;
        target  = {pc4_s[31:28], instru[25:0], 2'b00};
      end
      OP_RTYPE: begin
        if (funct_s == FN_JR) begin
          is_jump    = 1'b1;
          target     = align_word(rs_data);
          misaligned = (rs_data[1:0] != 2'b00);
        end else if (funct_s == FN_JALR) begin
          is_jump    = 1'b1;
          // rd==0 would be a discarded write: treat as a plain register jump
          is_link    = (rd_s != 5'd0);
          link_rd    = rd_s;
          target     = align_word(rs_data);
          misaligned = (rs_data[1:0] != 2'b00);
        end else begin
          is_jump = 1'b0;
        end
      end
      default: begin
        is_jump = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/jump_link_ctrl.sv
// Jump/link sequencer: accepts jumps from decode, arbitrates the RF write port
// between ALU writeback and the link write, and issues the fetch redirect.
module jump_link_ctrl
  import jump_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 4,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic               clk,
  input  logic               rst,
  jump_link_ctrl_if.slave    bus
);

  localparam int unsigned WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] MAX_WAIT_C = WCW'(MAX_WAIT);

  state_e         state_q, state_d;
  logic [31:0]    pc_out_q, pc_out_d;
  logic           pc_load_q, pc_load_d;
  logic           addr_err_q, addr_err_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [4:0]     link_addr_q, link_addr_d;
  logic [31:0]    link_data_q, link_data_d;
  logic [31:0]    target_q, target_d;

  logic [31:0]    calc_target_s;
  logic [31:0]    calc_link_s;
  logic [4:0]     calc_rd_s;
  logic           calc_jump_s;
  logic           calc_link_en_s;
  logic           calc_misal_s;
  logic           link_win_s;
  logic           rf_we_s;
  logic [4:0]     rf_waddr_s;
  logic [31:0]    rf_wdata_s;
  logic           alu_gnt_s;

  jump_target_calc #(
    .LINK_REG (LINK_REG)
  ) u_calc (
    .instru     (bus.instru),
    .pc_in      (bus.pc_in),
    .rs_data    (bus.rs_data),
    .target     (calc_target_s),
    .link_val   (calc_link_s),
    .link_rd    (calc_rd_s),
    .is_jump    (calc_jump_s),
    .is_link    (calc_link_en_s),
    .misaligned (calc_misal_s)
  );

  // The pending link takes the port when the ALU is idle or has been granted MAX_WAIT times
  assign link_win_s = (state_q == LINK_WAIT) &&
                      (!bus.alu_wr_req || (wait_cnt_q == MAX_WAIT_C));

  // Write-port mux: link write on a win, otherwise pass the ALU request straight through
  always_comb begin
    if (link_win_s) begin
      rf_we_s    = 1'b1;
      rf_waddr_s = link_addr_q;
      rf_wdata_s = link_data_q;
      alu_gnt_s  = 1'b0;
    end else begin
      rf_we_s    = bus.alu_wr_req;
      rf_waddr_s = bus.alu_wr_addr;
      rf_wdata_s = bus.alu_wr_data;
      alu_gnt_s  = bus.alu_wr_req;
    end
  end

  // Next-state and registered-output computation for the sequencer
  always_comb begin
    state_d     = state_q;
    pc_out_d    = pc_out_q;
    pc_load_d   = 1'b0;
    addr_err_d  = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    link_addr_d = link_addr_q;
    link_data_d = link_data_q;
    target_d    = target_q;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid && calc_jump_s) begin
          target_d   = calc_target_s;
          addr_err_d = calc_misal_s;
          if (calc_link_en_s) begin
            link_addr_d = calc_rd_s;
            link_data_d = calc_link_s;
            wait_cnt_d  = '0;
            state_d     = LINK_WAIT;
          end else begin
            pc_out_d  = calc_target_s;
            pc_load_d = 1'b1;
            state_d   = REDIRECT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LINK_WAIT: begin
        if (link_win_s) begin
          wait_cnt_d = '0;
          pc_out_d   = target_q;
          pc_load_d  = 1'b1;
          state_d    = REDIRECT;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      REDIRECT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_out_q    <= RESET_PC;
      pc_load_q   <= 1'b0;
      addr_err_q  <= 1'b0;
      wait_cnt_q  <= '0;
      link_addr_q <= 5'd0;
      link_data_q <= 32'h0000_0000;
      target_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_out_q    <= pc_out_d;
      pc_load_q   <= pc_load_d;
      addr_err_q  <= addr_err_d;
      wait_cnt_q  <= wait_cnt_d;
      link_addr_q <= link_addr_d;
      link_data_q <= link_data_d;
      target_q    <= target_d;
    end
  end

  assign bus.stall      = (state_q != IDLE);
  assign bus.pc_out     = pc_out_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.rf_we      = rf_we_s;
  assign bus.rf_waddr   = rf_waddr_s;
  assign bus.rf_wdata   = rf_wdata_s;
  assign bus.alu_wr_gnt = alu_gnt_s;

endmodule

// File: doc/jump_link_ctrl.md
Name: jump_link_ctrl

Overview:
- Sequencer for the jump/link datapath.
- Decodes J, JAL, JR and JALR from the decode stage and computes the jump target.
- Shares the register-file write port between the ALU writeback and the link-address write.
- Drives the PC load pulse that redirects fetch, and stalls decode while a jump is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, pc_out value after reset.
- MAX_WAIT, 4, maximum cycles a pending link write yields the write port to the ALU before it takes priority.
- LINK_REG, 5'd31, destination register for JAL.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- instru  in  32  instruction in decode
- instr_valid  in  1  instru/pc_in valid this cycle
- pc_in  in  32  PC of the instruction in decode
- rs_data  in  32  register rs value (JR/JALR target)
- alu_wr_req  in  1  ALU writeback requests the RF write port
- alu_wr_addr  in  5  ALU writeback register
- alu_wr_data  in  32  ALU writeback data
- alu_wr_gnt  out  1  ALU write accepted this cycle
- rf_we  out  1  RF write enable
- rf_waddr  out  5  RF write address
- rf_wdata  out  32  RF write data
- pc_out  out  32  redirect target (registered)
- pc_load  out  1  one-cycle pulse: fetch loads pc_out
- stall  out  1  decode must hold instru/pc_in
- addr_err  out  1  one-cycle pulse: misaligned JR/JALR target

Behaviour:
- Reset (rst=0, asynchronous), all values take effect immediately:
  - state=IDLE
  - pc_out=RESET_PC
  - pc_load=0, addr_err=0, wait_cnt=0
  - link_addr=0, link_data=0, target=0
- stall = (state != IDLE). It is combinational.
- Link value is pc_in+4. There is no delay slot. Arithmetic is mod 2^32, so 32'hFFFF_FFFC+4 wraps to 0.
- IDLE, acting only on instr_valid=1:
  - J (op 000010): target={pc4[31:28], instru[25:0], 2'b00}. Go to REDIRECT.
  - JAL (op 000011): same target; link_addr=LINK_REG; link_data=pc4. Go to LINK_WAIT.
  - JR (op 0, funct 001000): target={rs_data[31:2], 2'b00}. addr_err pulses if rs_data[1:0]!=0. Go to REDIRECT.
  - JALR (op 0, funct 001001): target as JR; link_addr=instru[15:11]. If rd==0, go to REDIRECT with no write; otherwise go to LINK_WAIT.
  - Any other opcode: no action.
- LINK_WAIT:
  - Link wins the port if alu_wr_req=0 or wait_cnt==MAX_WAIT.
  - On a win: rf_we=1, rf_waddr=link_addr, rf_wdata=link_data, alu_wr_gnt=0, wait_cnt cleared, go to REDIRECT.
  - Otherwise: wait_cnt increments and the ALU is granted.
- REDIRECT: pc_out<=target at entry; pc_load=1 for exactly one cycle; go to IDLE.
- Write-port arbitration (combinational):
  - Outside a link win: alu_wr_gnt=alu_wr_req, rf_we=alu_wr_req, with the ALU address and data.
  - The ALU is never dropped silently. When not granted, it must hold its request.
- Latency, with T = cycle in which IDLE sees a valid jump:
  - J/JR: pc_load at T+1.
  - JAL with free port: write at T+1, pc_load at T+2.
  - Worst case: write at T+1+MAX_WAIT.
- Boundary cases:
  - instr_valid while stall=1 is ignored. Upstream holds the instruction.
  - A new jump cannot start in the REDIRECT cycle. IDLE resumes at T+2 at the earliest.
  - Reset asserted mid-LINK_WAIT discards the pending link write and performs no partial write.
  - A write to r0 from the ALU is passed through. The RF ignores it.

Decomposition:
- Package jump_pkg holds:
  - Opcode constants OP_J, OP_JAL, OP_RTYPE.
  - Funct constants FN_JR, FN_JALR.
  - State enum {IDLE, LINK_WAIT, REDIRECT}.
- One combinational sub-module, jump_target_calc: inputs instru, pc_in, rs_data; outputs target, link value, is_jump, is_link, misaligned.

Test Plan:
- J at pc_in=32'h0040_0010, instru=32'h0810_0040 -> pc_load at T+1, pc_out=32'h0040_0100, no RF write.
- JAL at pc_in=32'h1000_0000, instru=32'h0C00_0004, alu_wr_req=0 -> T+1: rf_we=1, waddr=31, wdata=32'h1000_0004. T+2: pc_load, pc_out=32'h1000_0010.
- JAL with alu_wr_req held 1 (MAX_WAIT=4) -> alu_wr_gnt=1 for 4 cycles, then link write at T+5 with alu_wr_gnt=0, pc_load at T+6.
- JALR rd=0 then JALR rd=5 with rs_data=32'h0000_2003:
  - rd=0 -> no write.
  - rd=5 -> r5=pc4.
  - Both -> pc_out=32'h0000_2000 and addr_err pulses once.
- rst driven low during LINK_WAIT -> immediately pc_out=RESET_PC, stall=0, no rf_we in the following cycle.
- instr_valid=1 held during stall -> only one pc_load per jump, and the second jump is accepted only after IDLE.
